// File: rtl/l1_refill_pkg.sv
// Shared types for the L1 refill arbiter: FSM states, transaction owner and
// the holding-register payload layout.
package l1_refill_pkg;

  localparam int TXN_ADDR_W = 32;
  localparam int TXN_DATA_W = 32;
  localparam logic [31:0] WATCHDOG_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } arb_state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_e;

  typedef struct packed {
    logic                    wr;
    logic [TXN_ADDR_W-1:0]   addr;
    logic [TXN_DATA_W-1:0]   wr_data;
    logic [TXN_DATA_W/8-1:0] wr_mask;
  } mem_txn_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, last-grant register
// advanced only when the caller accepts the grant.
module rr_arbiter2
  import l1_refill_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic       gnt_vld_o,
  output owner_e     gnt_o
);

  owner_e last_q;

  // req_i[0] is the instruction side, req_i[1] the data side
  always_comb begin
    gnt_o = OWN_I;
    if (req_i == 2'b11) begin
      gnt_o = (last_q == OWN_D) ? OWN_I : OWN_D;
    end else if (req_i == 2'b10) begin
      gnt_o = OWN_D;
    end
  end

  assign gnt_vld_o = |req_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= OWN_D;
    end else if (upd_i && gnt_vld_o) begin
      last_q <= gnt_o;
    end
  end

endmodule

// File: rtl/l1_refill_arbiter.sv
// Merges instruction and data L1 refill requests onto one main-memory port,
// one transaction at a time. Optional watchdog: define ARB_WATCHDOG_EN.
module l1_refill_arbiter
  import l1_refill_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rd_data,
  input  logic                d_req,
  input  logic                d_wr,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wr_data,
  input  logic [DATA_W/8-1:0] d_wr_mask,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rd_data,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wr_data,
  output logic [DATA_W/8-1:0] mem_wr_mask,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rd_data,
  output logic                err
);

  // The holding-register struct fixes the payload widths
  if (MAX_WAIT < 1 || ADDR_W != TXN_ADDR_W || DATA_W != TXN_DATA_W) begin : g_bad_cfg
    $error("l1_refill_arbiter: unsupported parameter combination");
  end

  arb_state_e        state_q;
  owner_e            owner_q;
  owner_e            gnt;
  logic              gnt_vld;
  mem_txn_t          txn_q;
  mem_txn_t          txn_d;
  logic              mem_req_q;
  logic              i_ack_q;
  logic              d_ack_q;
  logic              wd_fire;
  logic [DATA_W-1:0] i_rd_q;
  logic [DATA_W-1:0] d_rd_q;
  logic [DATA_W-1:0] rsp_data;

  rr_arbiter2 u_rr (
    .clk_i     (clk),
    .rst_i     (reset),
    .req_i     ({d_req, i_req}),
    .upd_i     (state_q == IDLE),
    .gnt_vld_o (gnt_vld),
    .gnt_o     (gnt)
  );

  // Instruction fetches are always plain reads
  always_comb begin
    txn_d = '0;
    if (gnt == OWN_D) begin
      txn_d.wr      = d_wr;
      txn_d.addr    = d_addr;
      txn_d.wr_data = d_wr_data;
      txn_d.wr_mask = d_wr_mask;
    end else begin
      txn_d.addr = i_addr;
    end
  end

  assign rsp_data = wd_fire ? DATA_W'(WATCHDOG_DATA) : mem_rd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      txn_q     <= '0;
      mem_req_q <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rd_q    <= '0;
      d_rd_q    <= '0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            owner_q   <= gnt;
            txn_q     <= txn_d;
            mem_req_q <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ack || wd_fire) begin
            mem_req_q <= 1'b0;
            state_q   <= RESP;
            if (owner_q == OWN_I) begin
              i_ack_q <= 1'b1;
              i_rd_q  <= rsp_data;
            end else begin
              d_ack_q <= 1'b1;
              // a completed write leaves the data-side read register alone
              if (!txn_q.wr || wd_fire) d_rd_q <= rsp_data;
            end
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(MAX_WAIT + 1);

  logic [WD_W-1:0] wd_cnt_q;
  logic            err_q;

  assign wd_fire = (state_q == ISSUE) && !mem_ack && (wd_cnt_q == WD_W'(MAX_WAIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == ISSUE && !mem_ack && !wd_fire) wd_cnt_q <= wd_cnt_q + 1'b1;
      else wd_cnt_q <= '0;
      if (wd_fire) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign wd_fire = 1'b0;
  assign err     = 1'b0;
`endif

  assign mem_req     = mem_req_q;
  assign mem_wr      = txn_q.wr;
  assign mem_addr    = txn_q.addr;
  assign mem_wr_data = txn_q.wr_data;
  assign mem_wr_mask = txn_q.wr_mask;
  assign i_ack       = i_ack_q;
  assign i_rd_data   = i_rd_q;
  assign d_ack       = d_ack_q;
  assign d_rd_data   = d_rd_q;

endmodule

// File: doc/l1_refill_arbiter.md
Name: l1_refill_arbiter

Overview:
- Downstream neighbour of the two L1 memory modules (instruction and data).
- Merges their backing-store requests onto a single main-memory port.
- Single-word transactions (read or masked write); round-robin arbitration; one outstanding transaction at a time.
- Registered request/response handshakes on both sides; the core never sees this block directly.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width; mask width is DATA_W/8.
- MAX_WAIT, 255, watchdog limit in cycles (used only with ARB_WATCHDOG_EN).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  synchronous, active-high.
- i_req  in  1  instruction L1 request; held until i_ack.
- i_addr  in  ADDR_W  instruction read address.
- i_ack  out  1  one-cycle pulse: i_rd_data valid.
- i_rd_data  out  DATA_W  read data for the instruction side.
- d_req  in  1  data L1 request; held until d_ack.
- d_wr  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wr_data  in  DATA_W  write data.
- d_wr_mask  in  DATA_W/8  byte enables.
- d_ack  out  1  one-cycle completion pulse.
- d_rd_data  out  DATA_W  read data for the data side.
- mem_req  out  1  memory request; held until mem_ack.
- mem_wr  out  1  write strobe qualifier.
- mem_addr  out  ADDR_W  memory address.
- mem_wr_data  out  DATA_W  memory write data.
- mem_wr_mask  out  DATA_W/8  memory byte enables.
- mem_ack  in  1  one-cycle pulse from memory: done, mem_rd_data valid.
- mem_rd_data  in  DATA_W  memory read data.
- err  out  1  sticky watchdog error (tied 0 without the feature).

Behaviour:
- FSM states IDLE, ISSUE, RESP. Reset (synchronous, active-high) forces IDLE.
- Reset values of all outputs are 0. last_grant resets to D, so I wins the first tie.
- Reset mid-transaction: the FSM drops to IDLE and mem_req deasserts next cycle; any in-flight mem_ack is ignored.
- IDLE:
  - Single requester: grant it.
  - Both requesting: grant the side that is not last_grant, then update last_grant.
  - On grant: latch addr/wr/wr_data/wr_mask and the owner into holding registers; go to ISSUE.
  - I-side transactions always use wr=0 and mask=0.
- ISSUE:
  - mem_req=1 and mem_* driven from the holding registers; stable until mem_ack.
  - On mem_ack: capture mem_rd_data into the owner's rd_data register; go to RESP.
- RESP:
  - Owner's ack=1 for exactly one cycle; rd_data is held until the next capture. Go to IDLE.
  - Writes still pulse d_ack; d_rd_data is left unchanged.
- Latency: req high in cycle N gives mem_req in N+1. mem_ack in cycle M gives requester ack in M+1. Minimum 3 cycles req→ack with 0-wait memory.
- Requesters must drop req the cycle after ack. Req is ignored during ISSUE/RESP.
- Changing a req's payload while pending has no effect; payload is latched at grant.
- mem_ack seen outside ISSUE is ignored.
- Back-to-back: a loser requester still high is granted in the IDLE cycle following RESP.

Optional Feature:
- Macro ARB_WATCHDOG_EN.
- Defined:
  - A cycle counter runs in ISSUE and clears on leaving ISSUE.
  - Counter reaching MAX_WAIT sets err (sticky until reset), aborts to RESP and acks the owner with rd_data=32'hDEAD_BEEF.
- Undefined: no counter; err tied 0; ISSUE waits indefinitely.

Decomposition:
- Package l1_refill_pkg:
  - arb_state_e enum (IDLE, ISSUE, RESP).
  - owner_e enum (OWN_I, OWN_D).
  - WATCHDOG_DATA constant 32'hDEAD_BEEF.
  - mem_txn_t struct (wr, addr, wr_data, wr_mask).
- Sub-module rr_arbiter2: 2-input round-robin grant plus last_grant register, combinational grant, update enable.

Test Plan:
- I-only read, addr 0x100, memory returns 0x00000013 after 2 wait cycles → mem_req from cycle 1, i_ack pulse in cycle 5, i_rd_data=0x13, d_ack never high.
- D write, addr 0x2004, data 0xA5A5A5A5, mask 4'b0011 → mem_wr=1 with exact payload, d_ack one cycle, d_rd_data unchanged.
- i_req and d_req rise together, repeated 4 times after reset → grant order I,D,I,D; mem_addr sequence matches.
- d_addr changed from 0x40 to 0x80 during ISSUE → mem_addr stays 0x40 until mem_ack.
- Reset asserted in ISSUE, then a late mem_ack → all outputs 0 next cycle, no ack pulse, FSM in IDLE.
- ARB_WATCHDOG_EN with MAX_WAIT=8, no mem_ack → err=1 and d_ack with d_rd_data=0xDEADBEEF after 8 ISSUE cycles; err stays high until reset.
